// File: rtl/vga_pkg.sv
// Shared VGA constants: image geometry, frame-buffer address width and the colour-bar palette.
package vga_pkg;

   localparam int unsigned c_img_cols  = 320;
   localparam int unsigned c_img_rows  = 240;
   localparam int unsigned c_nb_addr   = 17;
   localparam int unsigned c_bar_width = 40;
   localparam int unsigned c_nb_bars   = 8;

   typedef logic [11:0] rgb444_t;

   typedef enum logic [2:0] {
      BAR_WHITE,
      BAR_YELLOW,
      BAR_CYAN,
      BAR_GREEN,
      BAR_MAGENTA,
      BAR_RED,
      BAR_BLUE,
      BAR_BLACK
   } bar_t;

   function automatic rgb444_t bar_color(input bar_t b);
      case (b)
         BAR_WHITE:   return 12'hFFF;
         BAR_YELLOW:  return 12'hFF0;
         BAR_CYAN:    return 12'h0FF;
         BAR_GREEN:   return 12'h0F0;
         BAR_MAGENTA: return 12'hF0F;
         BAR_RED:     return 12'hF00;
         BAR_BLUE:    return 12'h00F;
         default:     return 12'h000;
      endcase
   endfunction

endpackage

// File: rtl/vga_colorbars.sv
// Combinational colour-bar generator: eight bars, each c_bar_width columns wide.
module vga_colorbars
   import vga_pkg::*;
(
   input  logic [9:0]  i_col,
   output logic [11:0] o_color
);

   bar_t w_bar;

   // Bar index is col/40, found by threshold compares instead of a divider.
   always_comb begin
      w_bar = BAR_WHITE;
      for (int unsigned i = 1; i < c_nb_bars; i++) begin
         if ({22'd0, i_col} >= i * c_bar_width)
            w_bar = bar_t'(i[2:0]);
      end
   end

   assign o_color = bar_color(w_bar);

endmodule

// File: rtl/vga_frame_reader.sv
// Reads an RGB444 frame buffer (or colour bars) in step with the VGA timing generator,
// delaying syncs by one pixel so they stay aligned with the colour outputs.
module vga_frame_reader #(
   parameter int unsigned c_img_cols  = vga_pkg::c_img_cols,
   parameter int unsigned c_img_rows  = vga_pkg::c_img_rows,
   parameter int unsigned c_nb_addr   = vga_pkg::c_nb_addr,
   parameter logic [11:0] c_bg_color  = 12'h000,
   parameter logic        c_synch_act = 1'b0
) (
   input  logic                 rst,
   input  logic                 clk,
   input  logic                 new_pxl,
   input  logic                 visible_in,
   input  logic                 hsync_in,
   input  logic                 vsync_in,
   input  logic [9:0]           col,
   input  logic [9:0]           row,
   input  logic                 test_mode,
   input  logic [11:0]          mem_dout,
   output logic [c_nb_addr-1:0] mem_addr,
   output logic [3:0]           red,
   output logic [3:0]           green,
   output logic [3:0]           blue,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 frame_end
);

   localparam logic [9:0] c_cols_w = 10'(c_img_cols);
   localparam logic [9:0] c_rows_w = 10'(c_img_rows);

   logic                 w_in_img;
   logic [c_nb_addr-1:0] w_addr;
   vga_pkg::rgb444_t     w_bar;
   vga_pkg::rgb444_t     w_color;

   logic                 r_vis_d;
   logic                 r_img_d;
   logic                 r_hs_d;
   logic                 r_vs_d;
   logic                 r_test;
   vga_pkg::rgb444_t     r_bar_d;
   vga_pkg::rgb444_t     r_mem_q;

   assign w_in_img = visible_in && (col < c_cols_w) && (row < c_rows_w);
   // row*320 + col as row*256 + row*64 + col
   assign w_addr   = (c_nb_addr'(row) << 8) + (c_nb_addr'(row) << 6) + c_nb_addr'(col);

   vga_colorbars u_bars (
      .i_col   (col),
      .o_color (w_bar)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr <= '0;
         r_vis_d  <= 1'b0;
         r_img_d  <= 1'b0;
         r_hs_d   <= ~c_synch_act;
         r_vs_d   <= ~c_synch_act;
         r_bar_d  <= '0;
         r_test   <= 1'b0;
      end else if (new_pxl) begin
         if (w_in_img)
            mem_addr <= w_addr;
         r_vis_d <= visible_in;
         r_img_d <= w_in_img;
         r_hs_d  <= hsync_in;
         r_vs_d  <= vsync_in;
         r_bar_d <= w_bar;
         // Mode only changes at the frame origin so a frame is never split.
         if (col == '0 && row == '0)
            r_test <= test_mode;
      end
   end

   // Read data arrives on the edge between two pixel enables.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_mem_q <= '0;
      else if (!new_pxl)
         r_mem_q <= mem_dout;
   end

   always_comb begin
      w_color = '0;
      if (r_vis_d) begin
         if (!r_img_d)
            w_color = c_bg_color;
         else if (r_test)
            w_color = r_bar_d;
         else
            w_color = r_mem_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {red, green, blue} <= '0;
         hsync              <= ~c_synch_act;
         vsync              <= ~c_synch_act;
         frame_end          <= 1'b0;
      end else begin
         frame_end <= 1'b0;
         if (new_pxl) begin
            {red, green, blue} <= w_color;
            hsync              <= r_hs_d;
            vsync              <= r_vs_d;
            frame_end          <= (r_vs_d == c_synch_act) && (vsync != c_synch_act);
         end
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: pixel-by-pixel stimulus with a reference colour model.
`timescale 1ns/1ps
module tb_vga_frame_reader;

   localparam logic [11:0] c_bg = 12'h5A3;

   logic        rst, clk, new_pxl, visible_in, hsync_in, vsync_in, test_mode;
   logic [9:0]  col, row;
   logic [11:0] mem_dout;
   logic [16:0] mem_addr;
   logic [3:0]  red, green, blue;
   logic        hsync, vsync, frame_end;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [11:0] p_col;
   logic        p_hs, p_vs, q_vs, m_tm;
   int unsigned m_addr;
   logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                             12'hF0F, 12'hF00, 12'h00F, 12'h000};

   vga_frame_reader #(
      .c_img_cols  (320),
      .c_img_rows  (240),
      .c_nb_addr   (17),
      .c_bg_color  (c_bg),
      .c_synch_act (1'b0)
   ) dut (
      .rst        (rst),
      .clk        (clk),
      .new_pxl    (new_pxl),
      .visible_in (visible_in),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .col        (col),
      .row        (row),
      .test_mode  (test_mode),
      .mem_dout   (mem_dout),
      .mem_addr   (mem_addr),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .hsync      (hsync),
      .vsync      (vsync),
      .frame_end  (frame_end)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Frame buffer returns the low 12 address bits, valid before the capture edge.
   always @(negedge clk) mem_dout <= mem_addr[11:0];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] model_color(input int c, input int r, input logic vis,
                                               input logic tm);
      if (!vis) return 12'h000;
      if (c >= 320 || r >= 240) return c_bg;
      if (tm) return bars[c / 40];
      return 12'((r * 320 + c) % 4096);
   endfunction

   task automatic reset_model();
      p_col  = 12'h000;
      p_hs   = 1'b1;
      p_vs   = 1'b1;
      q_vs   = 1'b1;
      m_tm   = 1'b0;
      m_addr = 0;
   endtask

   // One pixel: present inputs for one new_pxl edge, then check the previous pixel's outputs.
   task automatic px(input int c, input int r, input logic vis, input logic hs, input logic vs);
      logic [11:0] e;
      logic        old_vs;
      @(negedge clk);
      check("fe_clr", frame_end, 1'b0);
      col        = c[9:0];
      row        = r[9:0];
      visible_in = vis;
      hsync_in   = hs;
      vsync_in   = vs;
      new_pxl    = 1'b1;
      if (c == 0 && r == 0) m_tm = test_mode;
      e = model_color(c, r, vis, m_tm);
      @(negedge clk);
      new_pxl = 1'b0;
      old_vs  = q_vs;
      q_vs    = p_vs;
      check("rgb", {red, green, blue}, p_col);
      check("hsync", hsync, p_hs);
      check("vsync", vsync, q_vs);
      check("frame_end", frame_end, old_vs && !q_vs);
      if (vis && c < 320 && r < 240) m_addr = r * 320 + c;
      check("mem_addr", mem_addr, m_addr);
      p_col = e;
      p_hs  = hs;
      p_vs  = vs;
   endtask

   initial begin
      rst = 1'b1; new_pxl = 1'b0; visible_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
      col = '0; row = '0; test_mode = 1'b0;
      reset_model();
      repeat (3) @(negedge clk);
      check("rst_rgb", {red, green, blue}, 12'h000);
      check("rst_addr", mem_addr, 0);
      check("rst_hsync", hsync, 1'b1);
      check("rst_vsync", vsync, 1'b1);
      check("rst_fe", frame_end, 1'b0);
      rst = 1'b0;

      px(0, 0, 1, 1, 1);
      px(4, 2, 1, 1, 1);
      px(5, 2, 1, 1, 1);
      check("addr_c5r2", mem_addr, 645);
      px(6, 2, 1, 1, 1);
      check("rgb_c5r2", {red, green, blue}, 12'h285);

      for (int c = 0; c < 320; c++) px(c, 1, 1, 1, 1);
      px(320, 1, 1, 1, 1);
      px(700, 1, 0, 0, 1);
      px(701, 1, 0, 1, 1);

      px(318, 239, 1, 1, 1);
      px(319, 239, 1, 1, 1);
      check("addr_last", mem_addr, 76799);
      px(320, 10, 1, 1, 1);
      check("rgb_last", {red, green, blue}, 12'hBFF);
      check("addr_hold", mem_addr, 76799);
      px(700, 10, 0, 1, 1);
      check("rgb_bg", {red, green, blue}, 12'h5A3);
      px(701, 10, 0, 1, 1);
      check("rgb_blank", {red, green, blue}, 12'h000);

      test_mode = 1'b1;
      px(10, 5, 1, 1, 1);
      px(11, 5, 1, 1, 1);
      px(12, 5, 1, 1, 1);
      check("tm_hold", {red, green, blue}, 12'h64B);
      for (int c = 0; c < 320; c++) begin
         px(c, 0, 1, 1, 1);
         if (c == 0)   check("addr_origin", mem_addr, 0);
         if (c == 1)   check("bar_c0", {red, green, blue}, 12'hFFF);
         if (c == 40)  check("bar_c39", {red, green, blue}, 12'hFFF);
         if (c == 41)  check("bar_c40", {red, green, blue}, 12'hFF0);
         if (c == 281) check("bar_c280", {red, green, blue}, 12'h000);
      end
      px(320, 0, 1, 1, 1);
      check("bar_c319", {red, green, blue}, 12'h000);

      px(0, 489, 0, 1, 1);
      px(1, 489, 0, 1, 0);
      check("vs_not_yet", vsync, 1'b1);
      px(2, 489, 0, 1, 0);
      check("vs_active", vsync, 1'b0);
      check("fe_pulse", frame_end, 1'b1);
      px(3, 489, 0, 1, 0);
      px(0, 491, 0, 1, 1);
      px(1, 491, 0, 1, 1);
      px(2, 491, 0, 1, 1);

      px(0, 0, 1, 1, 1);
      px(50, 3, 1, 0, 1);
      px(51, 3, 1, 0, 1);
      check("pre_rst_rgb", {red, green, blue}, 12'hFF0);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_rgb", {red, green, blue}, 12'h000);
      check("mid_rst_hsync", hsync, 1'b1);
      check("mid_rst_vsync", vsync, 1'b1);
      check("mid_rst_addr", mem_addr, 0);
      check("mid_rst_fe", frame_end, 1'b0);
      reset_model();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      px(4, 2, 1, 1, 1);
      check("rel_rgb", {red, green, blue}, 12'h000);
      px(5, 2, 1, 1, 1);
      px(6, 2, 1, 1, 1);
      check("realign", {red, green, blue}, 12'h285);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
